imem_unit: RTL and testbench

Byte-addressed Y86-64 instruction memory with a program-load port and a registered 10-byte fetch port. It sits directly upstream of the Fetch stage and supplies the 80-bit `current_instruction` window for the PC that Fetch presents. It also flags out-of-range PCs with the ADR status code. The memory is filled once after reset through a byte-serial load handshake; fetches are served only after loading completes.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/imem_unit_if.sv | 30 +++
 rtl/imem_byte_array.sv | 37 +++
 rtl/imem_unit.sv | 104 ++++++++++
 tb/tb_imem_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used across the pipeline stages.
// Provides the processor status codes, the instruction icodes, the
// fetch-window width and the instruction-memory FSM state type.
package y86_pkg;

   // Processor status codes (one-hot)
   localparam logic [3:0] STAT_AOK = 4'b1000;
   localparam logic [3:0] STAT_HLT = 4'b0100;
   localparam logic [3:0] STAT_ADR = 4'b0010;
   localparam logic [3:0] STAT_INS = 4'b0001;

   // Instruction codes (upper nibble of the first instruction byte)
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // Longest Y86-64 instruction, and so the fetch window, in bytes
   localparam int INSTR_BYTES = 10;

   typedef enum logic {
      IMEM_LOAD = 1'b0,
      IMEM_RUN  = 1'b1
   } imem_state_e;

endpackage

// File: rtl/imem_unit_if.sv
// Bundle of the instruction-memory load and fetch signals.
//   load side : load_valid/load_addr/load_data/load_done -> memory,
//               load_ready/bytes_loaded <- memory
//   fetch side: fetch_req/fetch_pc -> memory,
//               fetch_valid/fetch_instr/fetch_stat <- memory
// master = program loader / Fetch stage, slave = imem_unit.
// fetch_instr is numbered [0:79]: bits [0:7] hold the byte at the PC.
interface imem_unit_if;
   logic        load_valid;
   logic [9:0]  load_addr;
   logic [7:0]  load_data;
   logic        load_done;
   logic        load_ready;
   logic [10:0] bytes_loaded;
   logic        fetch_req;
   logic [63:0] fetch_pc;
   logic        fetch_valid;
   logic [0:79] fetch_instr;
   logic [3:0]  fetch_stat;

   modport master (
      output load_valid, load_addr, load_data, load_done, fetch_req, fetch_pc,
      input  load_ready, bytes_loaded, fetch_valid, fetch_instr, fetch_stat
   );

   modport slave (
      input  load_valid, load_addr, load_data, load_done, fetch_req, fetch_pc,
      output load_ready, bytes_loaded, fetch_valid, fetch_instr, fetch_stat
   );
endinterface

// File: rtl/imem_byte_array.sv
// Byte storage for the instruction memory.
//   clk              : write clock
//   wr_en/wr_addr/wr_data : single synchronous byte write port
//   rd_addr[i]       : 65-bit read addresses, one per fetch-window byte
//   rd_data[i]       : combinational read data, 8'h00 when out of range
// Contents are deliberately not reset so a program survives a core reset.
module imem_byte_array #(
   parameter int MEM_BYTES = 1024,
   parameter int NPORTS    = 10
) (
   input  logic        clk,
   input  logic        wr_en,
   input  logic [9:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic [64:0] rd_addr [NPORTS],
   output logic [7:0]  rd_data [NPORTS]
);

   logic [7:0] mem [MEM_BYTES];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Full-width compare so huge PCs never alias back into the array
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         rd_data[i] = 8'h00;
         if (rd_addr[i] < 65'(MEM_BYTES)) begin
            rd_data[i] = mem[rd_addr[i][9:0]];
         end
      end
   end

endmodule

// File: rtl/imem_unit.sv
// Y86-64 instruction memory: byte-serial program load followed by
// registered 10-byte instruction fetch.
//   clk : system clock
//   rst : asynchronous active-high reset (FSM, counter, outputs only)
//   bus : imem_unit_if.slave -- load handshake and fetch port
// After reset the unit is in LOAD and accepts byte writes; load_done moves
// it to RUN, where fetches are served with one cycle of latency and load
// writes are ignored. PCs at or beyond MEM_BYTES return ADR and a zero word.
module imem_unit
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic   clk,
   input  logic   rst,
   imem_unit_if.slave bus
);

   imem_state_e state_q, state_d;
   logic        wr_en;
   logic [10:0] cnt_q;
   logic [64:0] rd_addr [INSTR_BYTES];
   logic [7:0]  rd_data [INSTR_BYTES];
   logic [0:79] window;
   logic        pc_in_range;
   logic        vld_p1;
   logic [0:79] instr_p1;
   logic [3:0]  stat_p1;

   function automatic logic [10:0] sat_inc_cnt(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IMEM_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // A write presented together with load_done still commits
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      if (state_q == IMEM_LOAD) begin
         wr_en = bus.load_valid;
         if (bus.load_done) begin
            state_d = IMEM_RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 11'd0;
      end else if (wr_en) begin
         cnt_q <= sat_inc_cnt(cnt_q);
      end
   end

   imem_byte_array #(
      .MEM_BYTES (MEM_BYTES),
      .NPORTS    (INSTR_BYTES)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (bus.load_addr),
      .wr_data (bus.load_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // 65-bit addresses: pc+9 cannot wrap past 2^64 back to low memory
   always_comb begin
      for (int i = 0; i < INSTR_BYTES; i++) begin
         rd_addr[i]       = {1'b0, bus.fetch_pc} + 65'(i);
         window[8*i +: 8] = rd_data[i];
      end
   end

   // Only the first byte decides the status; a tail past the end is padding
   assign pc_in_range = (bus.fetch_pc < 64'(MEM_BYTES));

   // ---- stage p1: registered fetch result, held while fetch_req is low ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         instr_p1 <= '0;
         stat_p1  <= STAT_AOK;
      end else if ((state_q == IMEM_RUN) && bus.fetch_req) begin
         vld_p1   <= 1'b1;
         instr_p1 <= pc_in_range ? window : '0;
         stat_p1  <= pc_in_range ? STAT_AOK : STAT_ADR;
      end
   end

   assign bus.load_ready   = (state_q == IMEM_LOAD);
   assign bus.bytes_loaded = cnt_q;
   assign bus.fetch_valid  = vld_p1;
   assign bus.fetch_instr  = instr_p1;
   assign bus.fetch_stat   = stat_p1;

endmodule

// File: tb/tb_imem_unit.sv
// Bench for imem_unit: directed load/fetch sessions, a byte-array model of
// the memory checked against the DUT on every falling edge, and literal
// expectations for the documented example windows.
module tb_imem_unit;

   localparam int MEMB = 1024;
   localparam logic [3:0] AOK = 4'b1000;
   localparam logic [3:0] ADR = 4'b0010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   imem_unit_if bus ();

   imem_unit #(.MEM_BYTES(MEMB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [7:0]  m_mem [MEMB];
   logic        m_run;
   int          m_cnt;
   logic        m_vld;
   logic [79:0] m_instr;
   logic [3:0]  m_stat;

   function automatic logic [79:0] window_of(input logic [63:0] pc);
      logic [79:0] w;
      logic [64:0] a;
      w = '0;
      for (int i = 0; i < 10; i++) begin
         a = {1'b0, pc} + 65'(i);
         if (a < 65'(MEMB)) w[79-8*i -: 8] = m_mem[a[9:0]];
      end
      return w;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run   = 1'b0;
         m_cnt   = 0;
         m_vld   = 1'b0;
         m_instr = '0;
         m_stat  = AOK;
      end else if (!m_run) begin
         if (bus.load_valid) begin
            m_mem[bus.load_addr] = bus.load_data;
            if (m_cnt < 2047) m_cnt = m_cnt + 1;
         end
         if (bus.load_done) m_run = 1'b1;
      end else if (bus.fetch_req) begin
         m_vld = 1'b1;
         if (bus.fetch_pc >= 64'(MEMB)) begin
            m_stat  = ADR;
            m_instr = '0;
         end else begin
            m_stat  = AOK;
            m_instr = window_of(bus.fetch_pc);
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cyc_load_ready", 128'(bus.load_ready), 128'(!m_run));
      chk("cyc_bytes_loaded", 128'(bus.bytes_loaded), 128'(m_cnt));
      chk("cyc_fetch_valid", 128'(bus.fetch_valid), 128'(m_vld));
      chk("cyc_fetch_stat", 128'(bus.fetch_stat), 128'(m_stat));
      chk("cyc_fetch_instr", 128'(bus.fetch_instr), 128'(m_instr));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
      bus.load_valid = 1'b1;
      bus.load_addr  = a;
      bus.load_data  = d;
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic pulse_done();
      bus.load_done = 1'b1;
      tick();
      bus.load_done = 1'b0;
   endtask

   task automatic fetch(input logic [63:0] pc);
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = pc;
      tick();
      bus.fetch_req = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   logic [7:0]  vec0 [10] = '{8'h10, 8'h10, 8'h20, 8'h12, 8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [63:0] b2b  [10] = '{64'd0, 64'd1, 64'd100, 64'd1015, 64'd1016, 64'd1023,
                              64'd1024, 64'h8000_0000_0000_0000, 64'd513, 64'd5};

   initial begin
      #(200_000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.load_valid = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;
      bus.load_done  = 1'b0;
      bus.fetch_req  = 1'b0;
      bus.fetch_pc   = '0;
      tick();
      chk("rst_valid", 128'(bus.fetch_valid), 128'(0));
      chk("rst_instr", 128'(bus.fetch_instr), 128'(0));
      chk("rst_stat", 128'(bus.fetch_stat), 128'(AOK));
      chk("rst_load_ready", 128'(bus.load_ready), 128'(1));
      chk("rst_count", 128'(bus.bytes_loaded), 128'(0));
      rst = 1'b0;
      tick();

      // fetch while still loading is ignored
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = 64'd0;
      tick();
      tick();
      bus.fetch_req = 1'b0;
      chk("load_fetch_ignored", 128'(bus.fetch_valid), 128'(0));
      chk("load_ready_hi", 128'(bus.load_ready), 128'(1));
      chk("load_count0", 128'(bus.bytes_loaded), 128'(0));

      // session 1: example program
      for (int i = 0; i < 10; i++) load_byte(10'(i), vec0[i]);
      pulse_done();
      fetch(64'd0);
      chk("ex_instr", 128'(bus.fetch_instr), 128'(80'h1010_2012_30F2_0000_0000));
      chk("ex_stat", 128'(bus.fetch_stat), 128'(AOK));
      chk("ex_valid", 128'(bus.fetch_valid), 128'(1));
      chk("ex_count", 128'(bus.bytes_loaded), 128'(10));
      chk("run_ready_lo", 128'(bus.load_ready), 128'(0));

      // writes in RUN are ignored
      load_byte(10'd0, 8'hFF);
      fetch(64'd0);
      chk("run_wr_ignored", 128'(bus.fetch_instr[0:7]), 128'(8'h10));
      chk("run_wr_count", 128'(bus.bytes_loaded), 128'(10));

      // stall: outputs hold
      tick();
      tick();
      chk("stall_hold", 128'(bus.fetch_instr), 128'(80'h1010_2012_30F2_0000_0000));

      // asynchronous reset in the middle of a fetch
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = 64'd3;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", 128'(bus.fetch_valid), 128'(0));
      chk("arst_instr", 128'(bus.fetch_instr), 128'(0));
      bus.fetch_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // session 2: fill the rest, done + write together
      for (int a = 10; a < 1020; a++) load_byte(10'(a), 8'((a * 7 + 3) & 8'hFF));
      load_byte(10'd1020, 8'hAA);
      load_byte(10'd1021, 8'hBB);
      load_byte(10'd1022, 8'hCC);
      load_byte(10'd1023, 8'hDD);
      bus.load_valid = 1'b1;
      bus.load_addr  = 10'd5;
      bus.load_data  = 8'h77;
      pulse_done();
      bus.load_valid = 1'b0;
      chk("s2_count", 128'(bus.bytes_loaded), 128'(1015));
      fetch(64'd1020);
      chk("tail_instr", 128'(bus.fetch_instr), 128'(80'hAABB_CCDD_0000_0000_0000));
      chk("tail_stat", 128'(bus.fetch_stat), 128'(AOK));
      fetch(64'd1023);
      chk("last_byte", 128'(bus.fetch_instr), 128'(80'hDD00_0000_0000_0000_0000));
      fetch(64'd1024);
      chk("adr_stat", 128'(bus.fetch_stat), 128'(ADR));
      chk("adr_instr", 128'(bus.fetch_instr), 128'(0));
      fetch(64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_stat", 128'(bus.fetch_stat), 128'(ADR));
      chk("wrap_instr", 128'(bus.fetch_instr), 128'(0));
      fetch(64'd5);
      chk("same_cycle_wr", 128'(bus.fetch_instr[0:7]), 128'(8'h77));

      // back-to-back fetches, one result per cycle
      bus.fetch_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.fetch_pc = b2b[i];
         tick();
      end
      bus.fetch_req = 1'b0;
      tick();

      // session 3: reload with load_done only, contents survive
      do_reset();
      pulse_done();
      fetch(64'd0);
      chk("survive_instr", 128'(bus.fetch_instr), 128'(80'h1010_2012_3077_0000_0000));
      chk("survive_count", 128'(bus.bytes_loaded), 128'(0));

      // session 4: counter saturation
      do_reset();
      for (int i = 0; i < 2100; i++) load_byte(10'(i % 1024), 8'(i));
      chk("sat_count", 128'(bus.bytes_loaded), 128'(2047));
      pulse_done();
      fetch(64'd0);
      fetch(64'd1019);
      fetch(64'd700);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
